seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised multiplexed 7-segment display controller for the RISC-V tile's display output. The core writes hex digits into a DIGITS-entry buffer. The block time-multiplexes the buffer onto one shared segment bus, with per-digit one-hot select and anti-ghosting guard cycles. It is the multi-digit successor to the single-digit `segments[6:0]` output path.

## Interface
- `DIGITS`, 4: number of digits, 2..8.
- `SCAN_DIV`, 1024: clock cycles per digit slot, ≥ 4.
- `GUARD`, 2: blank cycles at the start of each slot, 1..SCAN_DIV-2.
- `ACTIVE_LOW`, 0: when 1, invert `segments` and `digit_sel` at the output registers.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe, sampled on `clk`.
- `wr_addr`  in  3  digit index; writes with `wr_addr ≥ DIGITS` are ignored.
- `wr_data`  in  6  bit 5 = blink (used only with the macro), bit 4 = blank, bits 3:0 = hex value.
- `segments`  out  7  bit 0 = a … bit 6 = g, registered.
- `digit_sel`  out  DIGITS  one-hot digit enable, registered.
- `frame_done`  out  1  one-cycle pulse per completed scan frame.

## Operation
- State:
  - prescaler `p`, 0..SCAN_DIV-1.
  - digit index `idx`, 0..DIGITS-1.
  - buffer `buf[DIGITS]`, 6 bits per entry.
- Every cycle `p` increments. At `p == SCAN_DIV-1`, `p` wraps to 0 and `idx` advances. `idx` wraps from DIGITS-1 to 0.
- Write: on a `clk` edge with `wr_en=1` and `wr_addr < DIGITS`, `buf[wr_addr] <= wr_data`.
  - A write and a scan advance on the same edge both take effect.
  - A write to the digit currently displayed is legal.
- Output registers load from the current state (`p`, `idx`, `buf[idx]`) on every edge:
  - `digit_sel`: all-off if `p < GUARD`, else one-hot(`idx`).
  - `segments`: all-off if `buf[idx][4]` = 1, else decode(`buf[idx][3:0]`).
- Decode table, hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- `frame_done` is registered. It is 1 for exactly one cycle following the edge where `idx` wraps DIGITS-1 → 0.
- `ACTIVE_LOW=1` inverts the value loaded into the `segments` and `digit_sel` registers; "all-off" then means all ones.
- Reset (`rst_n` low, asynchronous, at any time including mid-slot):
  - `p`=0, `idx`=0.
  - every `buf` entry = 6'b010000 (blank, no blink).
  - `segments` and `digit_sel` all-off in physical polarity; `frame_done`=0.
  - blink counter = 0.

## Timing
- Slot length is SCAN_DIV cycles; frame length is DIGITS×SCAN_DIV cycles.
- Outputs lag internal state by one cycle.
- Within a slot, `digit_sel` is off for the first GUARD output cycles and on for the remaining SCAN_DIV-GUARD cycles.
- Write-to-display latency: a write at edge E appears on `segments` at edge E+1 if that digit is selected then.
- After `rst_n` deasserts:
  - the first GUARD output cycles are all-off.
  - `digit_sel[0]` is then asserted with segments blank.
  - the first `frame_done` pulse comes DIGITS×SCAN_DIV cycles after the first active edge.
- No handshake: writes are accepted on every cycle, back-to-back.

## Configuration
- `SEG7_BLINK_EN` defined:
  - adds a 6-bit frame counter, incremented on each `frame_done` event and wrapping at 63.
  - a digit with `buf[i][5]`=1 is forced blank while frame counter bit 5 = 1, i.e. 32 frames on, 32 frames off.
- Not defined:
  - no frame counter.
  - `wr_data[5]` is stored but has no effect; behaviour is otherwise identical.

## Test plan
Bench configuration: DIGITS=4, SCAN_DIV=8, GUARD=2, ACTIVE_LOW=0.
1. Reset: hold `rst_n`=0, then release → `segments`=0 and `digit_sel`=0 for 2 cycles, then `digit_sel`=4'b0001 for 6 cycles with `segments`=0; `frame_done` first pulses 32 cycles after release.
2. Write addresses 0..3 with values 1, 2, 3, A (blank=0) → each slot shows 0x06/0001, 0x5B/0010, 0x4F/0100, 0x77/1000, each preceded by 2 guard cycles with `digit_sel`=0.
3. Write `wr_addr`=5, data 8 → no buffer change; the scan continues unchanged.
4. Write digit 2 = 0x10 (blank) while slot 2 is active → `segments`=0 from the next cycle; `digit_sel` stays 4'b0100.
5. ACTIVE_LOW=1 rerun of scenario 2 → `segments`=~0x06 and `digit_sel`=4'b1110 in slot 0; guard cycles show 4'b1111 on `digit_sel`.
6. With `SEG7_BLINK_EN` defined: write digit 0 = 0x28 (blink + 8) → shows 0x7F in frames 0..31 and 0 in frames 32..63. Without the macro → 0x7F in every frame.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment display controller. The core writes hex digits into a
//   DIGITS-entry buffer. The block scans that buffer onto a single shared segment
//   bus and drives a one-hot digit select. Each digit slot begins with GUARD blank
//   select cycles, so the previous digit's pattern does not ghost onto the next one.
//
//   Optional feature macro: SEG7_BLINK_EN
//     When defined, a 6-bit frame counter is added. Digits with the blink bit set
//     are blanked for 32 frames out of every 64.
//
//   Parameters
//     DIGITS      number of digits, 2..8
//     SCAN_DIV    clock cycles per digit slot, >= 4
//     GUARD       blank select cycles at slot start, 1..SCAN_DIV-2
//     ACTIVE_LOW  1 = invert segments and digit_sel at the output registers
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     wr_en       buffer write strobe
//     wr_addr     digit index; indices >= DIGITS are dropped
//     wr_data     {blink, blank, hex[3:0]}
//     segments    registered segment bus, bit 0 = a .. bit 6 = g
//     digit_sel   registered one-hot digit enable
//     frame_done  one-cycle pulse after each completed scan frame

// One buffer entry. There is one instance per digit.
module seg7_digit_slot (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [5:0] data,
   output logic [5:0] entry
);
   // Reset leaves the digit blank with blink cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    entry <= 6'b010000;
      else if (load) entry <= data;
   end
endmodule

module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 1024,
   parameter int GUARD      = 2,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [5:0]        wr_data,
   output logic [6:0]        segments,
   output logic [DIGITS-1:0] digit_sel,
   output logic              frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   // Physical "all-off" levels, which depend on output polarity.
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{ACTIVE_LOW}};

   logic [PW-1:0]            p;
   logic [IW-1:0]            idx;
   logic [DIGITS-1:0][5:0]   digit_buf;
   logic [5:0]               cur;
   logic                     slot_end;
   logic                     frame_end;
   logic                     blink_off;
   logic [6:0]               seg_nxt;
   logic [DIGITS-1:0]        sel_nxt;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // Scan timing: p counts cycles within a slot, and idx selects the digit.
   // ---------------------------------------------------------------------------
   assign slot_end  = (p == PW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p   <= '0;
         idx <= '0;
      end else begin
         p <= slot_end ? '0 : p + 1'b1;
         if (slot_end)
            idx <= frame_end ? '0 : idx + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit buffer. Out-of-range addresses match no slot, so they are dropped.
   // A write to the digit being shown is picked up by the next output load.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < DIGITS; i++) begin : g_slot
      seg7_digit_slot u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (wr_en && (wr_addr == 3'(i))),
         .data  (wr_data),
         .entry (digit_buf[i])
      );
   end

   assign cur = digit_buf[idx];

   // ---------------------------------------------------------------------------
   // Blink control
   // ---------------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
   logic [5:0] frame_cnt;

   // The counter advances on the same edge as the frame wrap. Frame k of the
   // display is therefore loaded with frame_cnt == k mod 64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         frame_cnt <= '0;
      else if (frame_end) frame_cnt <= frame_cnt + 1'b1;
   end

   assign blink_off = cur[5] & frame_cnt[5];
`else
   // The blink bit is stored but ignored in this build.
   assign blink_off = cur[5] & 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next output values, in logical (active-high) polarity.
   // Segments depend only on the blank state. The guard window is applied to the
   // select alone, so the new pattern settles while no digit is lit.
   // ---------------------------------------------------------------------------
   always_comb begin
      seg_nxt = '0;
      sel_nxt = '0;
      if (!(cur[4] || blink_off))
         seg_nxt = hex_decode(cur[3:0]);
      if (p >= PW'(GUARD))
         sel_nxt = DIGITS'(1) << idx;
   end

   // Output registers. Polarity is applied here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments   <= SEG_OFF;
         digit_sel  <= SEL_OFF;
         frame_done <= 1'b0;
      end else begin
         segments   <= seg_nxt ^ SEG_OFF;
         digit_sel  <= sel_nxt ^ SEL_OFF;
         frame_done <= frame_end;
      end
   end

endmodule
